// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the register bank controller.
package reg_bank_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic bit rd_lat_ok(input int lat);
        return (lat >= 1) && (lat <= 4);
    endfunction

endpackage

// File: rtl/reg_bank_storage.sv
// DEPTH x DATA_WIDTH register array with byte-strobe write and combinational read.
module reg_bank_storage #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  DEPTH      = 16,
    parameter int                  IDX_W      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [IDX_W-1:0]        ridx,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_d, mem_q;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) mem_d[widx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= {DEPTH{RESET_VAL}};
        else     mem_q <= mem_d;
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/reg_bank_ctrl.sv
// Register bank controller: sel/wr bus front end with range/RO decode,
// fixed-latency read responses and one-cycle error strobes.
module reg_bank_ctrl
    import reg_bank_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter int                    RD_LAT     = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [DEPTH-1:0]      RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    sel,
    input  logic                    wr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
        $error("RD_LAT must be within 1..4");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("DEPTH must be within 1..2**ADDR_WIDTH");
    end

    state_e                  state_d, state_q;
    logic [1:0]              cnt_d, cnt_q;
    logic                    ready_d, ready_q;
    logic                    rvalid_d, rvalid_q;
    logic                    err_d, err_q;
    logic [DATA_WIDTH-1:0]   rdata_d, rdata_q;
    logic [DATA_WIDTH-1:0]   hold_data_d, hold_data_q;
    logic                    hold_oor_d, hold_oor_q;

    logic [IDX_W-1:0]        idx;
    logic                    in_range, is_ro, accept, wr_ok;
    logic [DATA_WIDTH-1:0]   rd_word;

    assign idx      = addr[IDX_W-1:0];
    assign in_range = ({1'b0, addr} < (ADDR_WIDTH+1)'(DEPTH));
    assign is_ro    = in_range & RO_MASK[idx];
    assign accept   = sel & ready_q;
    assign wr_ok    = accept & wr & in_range & ~is_ro;

    reg_bank_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .RESET_VAL  (RESET_VAL)
    ) u_storage (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .widx  (idx),
        .wdata (wdata),
        .wstrb (wstrb),
        .ridx  (idx),
        .rdata (rd_word)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        rvalid_d    = 1'b0;
        err_d       = 1'b0;
        rdata_d     = '0;
        hold_data_d = hold_data_q;
        hold_oor_d  = hold_oor_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (wr) begin
                        err_d = ~in_range | is_ro;
                    end else begin
                        // Read data is captured now so a later write cannot leak into it.
                        state_d     = RD_WAIT;
                        cnt_d       = 2'(RD_LAT - 1);
                        ready_d     = 1'b0;
                        hold_data_d = in_range ? rd_word : ERR_DATA;
                        hold_oor_d  = ~in_range;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d  = IDLE;
                    ready_d  = 1'b1;
                    rvalid_d = 1'b1;
                    rdata_d  = hold_data_q;
                    err_d    = hold_oor_q;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            hold_data_q <= '0;
            hold_oor_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            hold_data_q <= hold_data_d;
            hold_oor_q  <= hold_oor_d;
        end
    end

    assign ready  = ready_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign err    = err_q;

endmodule
